// File: rtl/gate_beh.sv
// gate_beh
//   Registered five-input gate: o_y = NOT((a AND b) OR (c AND d AND e)),
//   evaluated from an explicit 32-entry truth table indexed by
//   n = {i_e, i_d, i_c, i_b, i_a}. The output changes only at a rising
//   clock edge, one cycle after the inputs are sampled.
//
// Ports
//   i_clk  in   rising-edge clock
//   i_rst  in   synchronous reset, active-high; forces o_y to 0
//   i_a    in   index bit 0
//   i_b    in   index bit 1
//   i_c    in   index bit 2
//   i_d    in   index bit 3
//   i_e    in   index bit 4
//   o_y    out  registered gate result
module gate_beh (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  input  logic i_d,
  input  logic i_e,
  output logic o_y
);

  logic [4:0] idx;
  logic       y_next;
  logic       y_reg;

  assign idx = {i_e, i_d, i_c, i_b, i_a};

  // Explicit truth table. Zeros sit where a&b (n[1:0]==2'b11) or
  // c&d&e (n[4:2]==3'b111) holds: 3,7,11,15,19,23,27,28,29,30,31.
  always_comb begin
    y_next = 1'b1;
    case (idx)
      5'd0:    y_next = 1'b1;
      5'd1:    y_next = 1'b1;
      5'd2:    y_next = 1'b1;
      5'd3:    y_next = 1'b0;
      5'd4:    y_next = 1'b1;
      5'd5:    y_next = 1'b1;
      5'd6:    y_next = 1'b1;
      5'd7:    y_next = 1'b0;
      5'd8:    y_next = 1'b1;
      5'd9:    y_next = 1'b1;
      5'd10:   y_next = 1'b1;
      5'd11:   y_next = 1'b0;
      5'd12:   y_next = 1'b1;
      5'd13:   y_next = 1'b1;
      5'd14:   y_next = 1'b1;
      5'd15:   y_next = 1'b0;
      5'd16:   y_next = 1'b1;
      5'd17:   y_next = 1'b1;
      5'd18:   y_next = 1'b1;
      5'd19:   y_next = 1'b0;
      5'd20:   y_next = 1'b1;
      5'd21:   y_next = 1'b1;
      5'd22:   y_next = 1'b1;
      5'd23:   y_next = 1'b0;
      5'd24:   y_next = 1'b1;
      5'd25:   y_next = 1'b1;
      5'd26:   y_next = 1'b1;
      5'd27:   y_next = 1'b0;
      5'd28:   y_next = 1'b0;
      5'd29:   y_next = 1'b0;
      5'd30:   y_next = 1'b0;
      5'd31:   y_next = 1'b0;
      // Unreachable for 0/1 inputs; matches the entry for index 0.
      default: y_next = 1'b1;
    endcase
  end

  // Reset wins over evaluation at the same edge; no other state is kept,
  // so nothing survives reset release except this single flop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      y_reg <= 1'b0;
    end else begin
      y_reg <= y_next;
    end
  end

  assign o_y = y_reg;

endmodule

// File: tb/tb_gate_beh.sv
module tb_gate_beh;

  logic clk;
  logic rst;
  logic a, b, c, d, e;
  logic y;

  int n_checks;
  int n_fails;

  gate_beh dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_a   (a),
    .i_b   (b),
    .i_c   (c),
    .i_d   (d),
    .i_e   (e),
    .o_y   (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the gate equation written directly from the index bits.
  function automatic logic ref_f(input int n);
    int ab, cde;
    ab  = ((n >> 0) & 1) * ((n >> 1) & 1);
    cde = ((n >> 2) & 1) * ((n >> 3) & 1) * ((n >> 4) & 1);
    return (ab + cde == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic check_val(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: o_y=%b expected %b", tag, got, exp);
    end
  endtask

  task automatic set_n(input int n);
    a = n[0]; b = n[1]; c = n[2]; d = n[3]; e = n[4];
  endtask

  // One transaction: drive at negedge, let one rising edge pass, then
  // sample 1 time unit after that edge.
  task automatic step(input string tag, input int n, input logic r);
    logic exp;
    @(negedge clk);
    set_n(n);
    rst = r;
    @(posedge clk);
    #1;
    exp = r ? 1'b0 : ref_f(n);
    $display("txn %s rst=%0b n=%0d o_y=%b exp=%b", tag, r, n, y, exp);
    check_val(tag, y, exp);
  endtask

  int dir_n[4];

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1;
    set_n(0);

    // Reset held two cycles with n=0, then release.
    step("reset0", 0, 1'b1);
    step("reset1", 0, 1'b1);
    step("release", 0, 1'b0);

    // Exhaustive sweep.
    for (int n = 0; n < 32; n++) step("sweep", n, 1'b0);

    // Directed cases.
    dir_n[0] = 5'b00011;
    dir_n[1] = 5'b11100;
    dir_n[2] = 5'b01101;
    dir_n[3] = 5'b10110;
    for (int i = 0; i < 4; i++) step("directed", dir_n[i], 1'b0);

    // Glitch between edges: 0 -> 3 -> 0 without crossing an edge.
    step("pre_glitch", 0, 1'b0);
    @(negedge clk);
    set_n(0);
    #1 set_n(3);
    #1 set_n(0);
    @(posedge clk);
    #1;
    $display("txn glitch n=0->3->0 o_y=%b exp=1", y);
    check_val("glitch", y, 1'b1);
    step("hold3", 3, 1'b0);
    step("hold3b", 3, 1'b0);

    // Reset mid-sweep at n=2, then resume.
    for (int n = 0; n < 3; n++) step("pre_rst", n, 1'b0);
    step("mid_rst", 2, 1'b1);
    for (int n = 2; n < 32; n++) step("resume", n, 1'b0);

    // Random traffic with occasional reset and repeated vectors.
    begin
      int n;
      n = 0;
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 3) != 0) n = int'($urandom_range(0, 31));
        step("rand", n, ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/gate_beh.md
GATE_BEH -- requirements
Module: gate_beh

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 Port list:
- i_clk  input  1  rising-edge clock
- i_rst  input  1  synchronous reset, active-high
- i_a  input  1  logic input a (index bit 0)
- i_b  input  1  logic input b (index bit 1)
- i_c  input  1  logic input c (index bit 2)
- i_d  input  1  logic input d (index bit 3)
- i_e  input  1  logic input e (index bit 4)
- o_y  output  1  registered gate-function result
REQ-003 The block SHALL have no parameters.
REQ-004 The block SHALL have no further ports.

Function
REQ-005 The block SHALL compute f = NOT((i_a AND i_b) OR (i_c AND i_d AND i_e)).
REQ-006 The input index SHALL be n = {i_e,i_d,i_c,i_b,i_a}, with i_a as the LSB.
REQ-007 f SHALL be defined as an explicit 32-entry truth table over n, one entry per index 0..31.
REQ-008 The truth table SHALL have exactly 21 entries at 1 and 11 at 0.
REQ-009 f SHALL be 0 exactly when (i_a=1 and i_b=1) or (i_c=1 and i_d=1 and i_e=1).
REQ-010 f SHALL be 1 for every other index.
REQ-011 The truth table SHALL have a default branch.
- The default SHALL drive 1, the same value as f for index 0.
- The default SHALL never be reachable for 0/1 inputs.
REQ-012 All five inputs SHALL be sampled on the rising edge of i_clk.
REQ-013 o_y SHALL update on the rising edge of i_clk only.
REQ-014 Latency SHALL be exactly 1 cycle: o_y after edge k equals f(inputs sampled at edge k).
REQ-015 Inputs SHALL be treated as asynchronous levels that may change at any time between edges.
REQ-016 o_y SHALL reflect only values present at a sampling edge.
REQ-017 Input glitches between edges SHALL NOT affect o_y.
REQ-018 There SHALL be no combinational path from any input to o_y.
REQ-019 An unchanged input vector SHALL hold o_y constant.
REQ-020 Any X/Z on an input SHALL NOT be masked: X-propagation follows normal simulation semantics.

Reset
REQ-021 When i_rst=1 at a rising edge, o_y SHALL become 0 at that edge, regardless of the inputs.
REQ-022 While i_rst stays 1, o_y SHALL remain 0.
REQ-023 Reset SHALL take priority over evaluation at the same edge.
REQ-024 At the first edge with i_rst=0, o_y SHALL take f of the inputs sampled at that edge.
REQ-025 Reset asserted in mid-operation SHALL force o_y to 0 at the next edge.
REQ-026 Reset SHALL leave no residual state after it is released.
REQ-027 Before the first reset edge, o_y is undefined.
- Benches SHALL apply reset for at least 1 cycle before checking o_y.

Verification
REQ-028 Reset: i_rst=1 for 2 cycles with inputs n=0 -> o_y=0 throughout.
- Release reset -> o_y=1 one edge later.
REQ-029 Exhaustive sweep of n=0..31, one index per clock, no reset.
- o_y one cycle later matches the truth table.
- 0 is expected at n = 3,7,11,15,19,23,27,28,29,30,31.
- 1 is expected at all other n.
REQ-030 Directed cases:
- n=5'b00011 (a=b=1) -> o_y=0
- n=5'b11100 (c=d=e=1) -> o_y=0
- n=5'b01101 (a,c,d) -> o_y=1
- n=5'b10110 -> o_y=1
REQ-031 Latency/glitch check:
- Toggle n from 0 to 3 and back to 0 entirely between two edges -> o_y stays 1.
- Hold n=3 across an edge -> o_y=0 exactly one cycle later.
REQ-032 Reset mid-sweep: assert i_rst at n=2 (o_y=1).
- o_y=0 at the next edge even though f(2)=1.
- After deassertion, the sweep resumes with correct 1-cycle-latency values.
